audio_serial_tx: RTL and testbench

Output-side serializer for the audio path: accepts processed 32-bit stereo samples (left in [31:16], right in [15:0]) from the effect datapath over a valid/ready handshake. It shifts each sample out MSB-first on a left-justified serial link (bclk, lrclk, sdata) to the DAC. It is the transmit counterpart of the serial input path that feeds 32-bit samples into the effects chain.

---
 rtl/audio_serial_tx.sv | 190 +++++++++++++++++++
 tb/tb_audio_serial_tx.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_serial_tx.sv
// ---------------------------------------------------------------------------
// audio_serial_tx
//
// Output-side serializer for the audio path. It takes 32-bit stereo samples
// (left in [31:16], right in [15:0]) over a valid/ready handshake. It shifts
// each sample out MSB-first on a left-justified serial link (bclk, lrclk,
// sdata) towards the DAC.
//
// One hold register (with a full flag) decouples the handshake from the
// serial frame timing. A sample accepted at any point during a frame is
// picked up at the next frame boundary. If no sample is held when a frame
// starts, that frame carries silence and underrun pulses.
//
// Ports:
//   clk           system clock, the only clock in the block
//   n_rst         asynchronous, active-low reset
//   tx_en         transmitter enable (level)
//   sample_valid  sample_data is valid
//   sample_data   stereo sample: [31:16] left, [15:0] right
//   sample_ready  hold register empty, a sample can be accepted
//   bclk          serial bit clock, period = 2*BCLK_DIV clk
//   lrclk         channel select: 0 = left half, 1 = right half
//   sdata         serial data, changes only when bclk falls (or on a load)
//   underrun      one-clk pulse when a frame starts with no sample held
//   busy          high whenever the transmitter is not idle
// ---------------------------------------------------------------------------
module audio_serial_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  tx_en,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_ready,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  underrun,
  output logic                  busy
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  full_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DIV_W-1:0]      div_cnt_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic                  bclk_reg;
  logic                  underrun_reg;

  logic div_wrap;
  logic fall_evt;
  logic frame_end;
  logic load_evt;
  logic accept;

  // Handshake: ready depends only on the full flag, so acceptance never
  // depends on tx_en or on the serializer state.
  assign sample_ready = !full_reg;
  assign accept       = sample_valid && !full_reg;

  // ------------------------------------------------------------------------
  // Next-state logic. A load happens either when leaving IDLE or at a frame
  // boundary while still running with tx_en high. This keeps frames
  // back-to-back with no bclk gap.
  // ------------------------------------------------------------------------
  always_comb begin
    div_wrap   = (state_reg != ST_IDLE) && (div_cnt_reg == DIV_LAST);
    fall_evt   = div_wrap && bclk_reg;
    frame_end  = fall_evt && (bit_cnt_reg == BIT_LAST);
    load_evt   = 1'b0;
    state_next = state_reg;

    case (state_reg)
      ST_IDLE: begin
        if (tx_en) begin
          load_evt   = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          if (tx_en) begin
            load_evt = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (!tx_en) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        // The current frame always completes. Re-enabling before the boundary
        // simply resumes RUN; the divider keeps going, so bclk has no glitch.
        if (frame_end) begin
          state_next = ST_IDLE;
        end else if (tx_en) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Hold register. Accept only fires while empty and the load only drains
  // while full, so the two can never collide on one edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_reg <= '0;
      full_reg <= 1'b0;
    end else if (accept) begin
      hold_reg <= sample_data;
      full_reg <= 1'b1;
    end else if (load_evt && full_reg) begin
      full_reg <= 1'b0;
    end
  end

  // Serial datapath: bclk divider, bit counter and output shifter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_reg    <= '0;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      bclk_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;
      if (load_evt) begin
        shift_reg    <= full_reg ? hold_reg : '0;
        underrun_reg <= !full_reg;
        div_cnt_reg  <= '0;
        bit_cnt_reg  <= '0;
        bclk_reg     <= 1'b0;
      end else if (state_reg == ST_IDLE) begin
        shift_reg   <= '0;
        div_cnt_reg <= '0;
        bit_cnt_reg <= '0;
        bclk_reg    <= 1'b0;
      end else if (div_wrap) begin
        div_cnt_reg <= '0;
        bclk_reg    <= !bclk_reg;
        if (fall_evt) begin
          if (frame_end) begin
            // Boundary without a reload: we are heading to IDLE, so park
            // sdata and lrclk low right away.
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            shift_reg   <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
    end
  end

  // The top bit of the bit counter flips exactly when the right-channel MSB
  // is shifted in, so lrclk lines up with each channel's MSB.
  assign bclk     = bclk_reg;
  assign sdata    = shift_reg[DATA_WIDTH-1];
  assign lrclk    = bit_cnt_reg[BIT_W-1];
  assign underrun = underrun_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_audio_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_audio_serial_tx
//
// Self-checking bench for audio_serial_tx. It uses a default instance
// (BCLK_DIV=4) and a BCLK_DIV=2 instance. A monitor decodes the serial link
// into whole frames: it samples sdata/lrclk on each bclk rise and notes when
// each frame begins. Each test compares those frames against the sample
// sequence the enable/handshake rules say should appear.
// ---------------------------------------------------------------------------
module tb_audio_serial_tx;

  localparam int DIV  = 4;
  localparam int DIV2 = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        tx_en = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_data = '0;
  logic        sample_ready, bclk, lrclk, sdata, underrun, busy;

  logic        tx_en2 = 1'b0;
  logic        sample_valid2 = 1'b0;
  logic [31:0] sample_data2 = '0;
  logic        sample_ready2, bclk2, lrclk2, sdata2, underrun2, busy2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  audio_serial_tx dut (
    .clk(clk), .n_rst(n_rst), .tx_en(tx_en), .sample_valid(sample_valid),
    .sample_data(sample_data), .sample_ready(sample_ready), .bclk(bclk),
    .lrclk(lrclk), .sdata(sdata), .underrun(underrun), .busy(busy)
  );

  audio_serial_tx #(.DATA_WIDTH(32), .BCLK_DIV(DIV2)) dut2 (
    .clk(clk), .n_rst(n_rst), .tx_en(tx_en2), .sample_valid(sample_valid2),
    .sample_data(sample_data2), .sample_ready(sample_ready2), .bclk(bclk2),
    .lrclk(lrclk2), .sdata(sdata2), .underrun(underrun2), .busy(busy2)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- link monitor, default instance ----------------
  logic        bclk_q = 1'b0, sdata_q = 1'b0, ur_q = 1'b0;
  logic [31:0] sh = '0, lrsh = '0;
  int          nb = 0, rises = 0, first_rise = 0;
  int          sd_glitch = 0, ur_count = 0, ur_wide = 0;
  logic [31:0] got_q[$];
  logic [31:0] lr_q[$];
  int          start_q[$];
  int          span_q[$];

  initial forever begin
    @(negedge clk);
    if (!n_rst) begin
      nb = 0;
    end else begin
      if (bclk && !bclk_q) begin
        rises++;
        sh   = {sh[30:0], sdata};
        lrsh = {lrsh[30:0], lrclk};
        if (nb == 0) begin
          first_rise = cyc;
          start_q.push_back(cyc);
        end
        nb++;
        if (nb == 32) begin
          got_q.push_back(sh);
          lr_q.push_back(lrsh);
          span_q.push_back(cyc - first_rise);
          nb = 0;
        end
      end
      if (bclk && (sdata !== sdata_q)) sd_glitch++;
      if (underrun && !ur_q) ur_count++;
      if (underrun && ur_q) ur_wide++;
    end
    bclk_q  = bclk;
    sdata_q = sdata;
    ur_q    = underrun;
  end

  // ---------------- link monitor, BCLK_DIV=2 instance ----------------
  logic        bclk2_q = 1'b0;
  logic [31:0] sh2 = '0, lrsh2 = '0;
  int          nb2 = 0, first2 = 0, ur2_count = 0;
  logic [31:0] got2_q[$];
  logic [31:0] lr2_q[$];
  int          start2_q[$];
  int          span2_q[$];

  initial forever begin
    @(negedge clk);
    if (!n_rst) begin
      nb2 = 0;
    end else begin
      if (bclk2 && !bclk2_q) begin
        sh2   = {sh2[30:0], sdata2};
        lrsh2 = {lrsh2[30:0], lrclk2};
        if (nb2 == 0) begin
          first2 = cyc;
          start2_q.push_back(cyc);
        end
        nb2++;
        if (nb2 == 32) begin
          got2_q.push_back(sh2);
          lr2_q.push_back(lrsh2);
          span2_q.push_back(cyc - first2);
          nb2 = 0;
        end
      end
      if (underrun2) ur2_count++;
    end
    bclk2_q = bclk2;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic clear_mon();
    got_q.delete(); lr_q.delete(); start_q.delete(); span_q.delete();
  endtask

  // Offers d until it is accepted. Called on a negedge; returns on the
  // negedge after the accepting posedge with sample_valid still high.
  task automatic push(input logic [31:0] d, output bit ok, output int rdy_cyc);
    sample_valid = 1'b1;
    sample_data  = d;
    ok = 1'b0;
    rdy_cyc = -1;
    for (int t = 0; t < 3000 && !ok; t++) begin
      if (sample_ready) begin
        rdy_cyc = cyc;
        ok = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_bits(input int frames, input int bits, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      if (got_q.size() >= frames && nb >= bits) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok, output int when);
    ok = 1'b0;
    when = 0;
    for (int t = 0; t < 3000; t++) begin
      if (!busy) begin
        ok = 1'b1;
        when = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ok;
    int rc, r0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bclk, lrclk, sdata, underrun, busy, sample_ready} !== 6'b000001) begin
      fails++;
      $display("FAIL reset_values: got %b, expected 000001",
               {bclk, lrclk, sdata, underrun, busy, sample_ready});
    end
    n_rst = 1'b1;
    repeat (10) @(negedge clk);
    tests++;
    if (rises !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_quiet: rises %0d busy %b, expected 0 0", rises, busy);
    end
    push(32'hDEAD_BEEF, ok, rc);
    sample_valid = 1'b0;
    tx_en = 1'b1;
    repeat (100) @(negedge clk);
    push(32'h1357_9BDF, ok, rc);
    sample_valid = 1'b0;
    #2 n_rst = 1'b0;
    tx_en = 1'b0;
    #1;
    tests++;
    if ({bclk, lrclk, sdata, underrun, busy, sample_ready} !== 6'b000001) begin
      fails++;
      $display("FAIL reset_async: got %b, expected 000001",
               {bclk, lrclk, sdata, underrun, busy, sample_ready});
    end
    @(negedge clk);
    n_rst = 1'b1;
    r0 = rises;
    repeat (20) @(negedge clk);
    tests++;
    if (rises !== r0) begin
      fails++;
      $display("FAIL reset_no_bclk: rises %0d, expected %0d", rises, r0);
    end
    tx_en = 1'b1;
    @(negedge clk);
    tests++;
    if (underrun !== 1'b1) begin
      fails++;
      $display("FAIL reset_discard: underrun %b, expected 1", underrun);
    end
    tx_en = 1'b0;
    wait_idle(ok, rc);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL reset_timeout: busy %b, expected 0", busy);
    end
  endtask

  task automatic test_single();
    bit ok1, ok2;
    int rc, u0;
    clear_mon();
    u0 = ur_count;
    push(32'hA5A5_3C3C, ok1, rc);
    sample_valid = 1'b0;
    tx_en = 1'b1;
    @(negedge clk);
    tests++;
    if (sdata !== 1'b1 || busy !== 1'b1 || underrun !== 1'b0) begin
      fails++;
      $display("FAIL single_first_bit: sdata %b busy %b underrun %b, expected 1 1 0",
               sdata, busy, underrun);
    end
    wait_bits(1, 1, ok1);
    tx_en = 1'b0;
    wait_idle(ok2, rc);
    tests++;
    if (!ok1 || !ok2 || got_q.size() != 2) begin
      fails++;
      $display("FAIL single_frames: got %0d frames, expected 2", got_q.size());
    end
    tests++;
    if (got_q[0] !== 32'hA5A5_3C3C) begin
      fails++;
      $display("FAIL single_data: got %h, expected a5a53c3c", got_q[0]);
    end
    tests++;
    if (lr_q[0] !== 32'h0000_FFFF) begin
      fails++;
      $display("FAIL single_lrclk: got %h, expected 0000ffff", lr_q[0]);
    end
    tests++;
    if (start_q[1] - start_q[0] !== 64 * DIV) begin
      fails++;
      $display("FAIL single_frame_len: got %0d, expected %0d", start_q[1] - start_q[0], 64 * DIV);
    end
    tests++;
    if (span_q[0] !== 31 * 2 * DIV) begin
      fails++;
      $display("FAIL single_bclk_period: 31 periods took %0d, expected %0d", span_q[0], 62 * DIV);
    end
    tests++;
    if (got_q[1] !== 32'h0 || ur_count - u0 !== 1) begin
      fails++;
      $display("FAIL single_tail_underrun: data %h pulses %0d, expected 0 1", got_q[1], ur_count - u0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [6];
    int          rdy [6];
    bit          ok, ok2;
    int          rc, u0;
    clear_mon();
    u0 = ur_count;
    w[0] = 32'h8000_0001;
    w[1] = 32'h7FFF_FFFE;
    w[2] = 32'h1234_5678;
    for (int k = 3; k < 6; k++) w[k] = $urandom;
    for (int k = 0; k < 6; k++) begin
      push(w[k], ok, rdy[k]);
      if (k == 0) tx_en = 1'b1;
      tests++;
      if (!ok || sample_ready !== 1'b0) begin
        fails++;
        $display("FAIL b2b_ready_drop[%0d]: ok %b ready %b, expected 1 0", k, ok, sample_ready);
      end
    end
    sample_valid = 1'b0;
    wait_bits(5, 1, ok);
    tx_en = 1'b0;
    wait_idle(ok2, rc);
    tests++;
    if (!ok || !ok2 || got_q.size() != 6) begin
      fails++;
      $display("FAIL b2b_frames: got %0d frames, expected 6", got_q.size());
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (got_q[k] !== w[k]) begin
        fails++;
        $display("FAIL b2b_data[%0d]: got %h, expected %h", k, got_q[k], w[k]);
      end
    end
    for (int k = 1; k < 6; k++) begin
      tests++;
      if (start_q[k] - start_q[k-1] !== 64 * DIV) begin
        fails++;
        $display("FAIL b2b_gap[%0d]: spacing %0d, expected %0d", k, start_q[k] - start_q[k-1], 64 * DIV);
      end
      tests++;
      if (rdy[k] + DIV !== start_q[k-1]) begin
        fails++;
        $display("FAIL b2b_ready_rise[%0d]: ready at %0d, expected %0d", k, rdy[k], start_q[k-1] - DIV);
      end
    end
    tests++;
    if (ur_count !== u0) begin
      fails++;
      $display("FAIL b2b_underrun: pulses %0d, expected 0", ur_count - u0);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] r;
    bit          ok1, ok2, ok3;
    int          rc, u0;
    clear_mon();
    u0 = ur_count;
    tx_en = 1'b1;
    @(negedge clk);
    tests++;
    if (underrun !== 1'b1) begin
      fails++;
      $display("FAIL underrun_pulse: got %b, expected 1", underrun);
    end
    @(negedge clk);
    tests++;
    if (underrun !== 1'b0) begin
      fails++;
      $display("FAIL underrun_width: got %b, expected 0", underrun);
    end
    wait_bits(0, 8, ok1);
    r = $urandom;
    push(r, ok2, rc);
    sample_valid = 1'b0;
    wait_bits(1, 1, ok3);
    tx_en = 1'b0;
    wait_idle(ok1, rc);
    tests++;
    if (!ok1 || !ok2 || !ok3 || got_q.size() != 2) begin
      fails++;
      $display("FAIL underrun_frames: got %0d frames, expected 2", got_q.size());
    end
    tests++;
    if (got_q[0] !== 32'h0 || got_q[1] !== r) begin
      fails++;
      $display("FAIL underrun_data: got %h %h, expected 00000000 %h", got_q[0], got_q[1], r);
    end
    tests++;
    if (ur_count - u0 !== 1 || ur_wide !== 0) begin
      fails++;
      $display("FAIL underrun_count: pulses %0d wide %0d, expected 1 0", ur_count - u0, ur_wide);
    end
  endtask

  task automatic test_stop();
    bit ok1, ok2;
    int rc, when, u0, r0;
    clear_mon();
    u0 = ur_count;
    push(32'h0F0F_F0F0, ok1, rc);
    sample_valid = 1'b0;
    tx_en = 1'b1;
    wait_bits(0, 11, ok1);
    tx_en = 1'b0;
    wait_idle(ok2, when);
    tests++;
    if (!ok1 || !ok2 || {bclk, lrclk, sdata} !== 3'b000) begin
      fails++;
      $display("FAIL stop_idle_outputs: bclk/lrclk/sdata %b, expected 000", {bclk, lrclk, sdata});
    end
    tests++;
    if (got_q.size() != 1 || got_q[0] !== 32'h0F0F_F0F0) begin
      fails++;
      $display("FAIL stop_data: got %h (%0d frames), expected 0f0ff0f0", got_q[0], got_q.size());
    end
    tests++;
    if (when - start_q[0] !== 63 * DIV) begin
      fails++;
      $display("FAIL stop_timing: idle %0d after first bit, expected %0d", when - start_q[0], 63 * DIV);
    end
    r0 = rises;
    repeat (20) @(negedge clk);
    tests++;
    if (rises !== r0 || busy !== 1'b0 || ur_count !== u0) begin
      fails++;
      $display("FAIL stop_quiet: rises %0d busy %b pulses %0d, expected 0 0 0",
               rises - r0, busy, ur_count - u0);
    end
    tests++;
    if (sd_glitch !== 0) begin
      fails++;
      $display("FAIL sdata_edge: %0d changes while bclk high, expected 0", sd_glitch);
    end
  endtask

  task automatic test_div2();
    int t;
    got2_q.delete(); lr2_q.delete(); start2_q.delete(); span2_q.delete();
    tests++;
    if (sample_ready2 !== 1'b1) begin
      fails++;
      $display("FAIL div2_ready: got %b, expected 1", sample_ready2);
    end
    sample_data2  = 32'hA5A5_3C3C;
    sample_valid2 = 1'b1;
    @(negedge clk);
    sample_valid2 = 1'b0;
    tx_en2 = 1'b1;
    for (t = 0; t < 2000 && start2_q.size() < 2; t++) @(negedge clk);
    tx_en2 = 1'b0;
    for (t = 0; t < 2000 && busy2; t++) @(negedge clk);
    tests++;
    if (busy2 !== 1'b0 || got2_q.size() != 2) begin
      fails++;
      $display("FAIL div2_frames: got %0d frames busy %b, expected 2 0", got2_q.size(), busy2);
    end
    tests++;
    if (got2_q[0] !== 32'hA5A5_3C3C || lr2_q[0] !== 32'h0000_FFFF) begin
      fails++;
      $display("FAIL div2_data: got %h lr %h, expected a5a53c3c 0000ffff", got2_q[0], lr2_q[0]);
    end
    tests++;
    if (start2_q[1] - start2_q[0] !== 128) begin
      fails++;
      $display("FAIL div2_frame_len: got %0d, expected 128", start2_q[1] - start2_q[0]);
    end
    tests++;
    if (span2_q[0] !== 31 * 4) begin
      fails++;
      $display("FAIL div2_bclk_period: 31 periods took %0d, expected 124", span2_q[0]);
    end
    tests++;
    if (ur2_count !== 1) begin
      fails++;
      $display("FAIL div2_underrun: pulse clks %0d, expected 1", ur2_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_stop();
    test_div2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
